// File: rtl/palette_pixel_shifter_pkg.sv
// Shared video constants, row payload type and row-shift helpers for the palette pixel path.
package palette_pixel_shifter_pkg;

    localparam int unsigned PIX_PER_ROW = 8;
    localparam int unsigned BPP         = 4;
    localparam int unsigned PAL_SEL_W   = 3;
    localparam int unsigned ENTRY_W     = 16;
    localparam int unsigned COLOR_W     = 12;
    localparam int unsigned ROW_W       = PIX_PER_ROW * BPP;
    localparam int unsigned N_ENTRIES   = 1 << BPP;
    localparam int unsigned PAL_ROW_W   = ENTRY_W * N_ENTRIES;
    localparam int unsigned CNT_W       = $clog2(PIX_PER_ROW + 1);

    localparam logic [COLOR_W-1:0] BG_COLOR = 12'h000;

    typedef struct packed {
        logic [ROW_W-1:0]     data;
        logic [PAL_SEL_W-1:0] pal;
        logic                 hflip;
    } row_t;

    // Index of the pixel the row emits next (top nibble when mirrored).
    function automatic logic [BPP-1:0] row_head(input row_t r);
        return r.hflip ? r.data[ROW_W-1 -: BPP] : r.data[BPP-1:0];
    endfunction

    function automatic row_t row_advance(input row_t r);
        row_t o;
        o      = r;
        o.data = r.hflip ? (r.data << BPP) : (r.data >> BPP);
        return o;
    endfunction

endpackage

// File: rtl/palette_pixel_shifter_if.sv
// Row input, pixel strobe, palette RAM and RGB output signals of the palette pixel shifter.
interface palette_pixel_shifter_if;
    import palette_pixel_shifter_pkg::*;

    logic                 row_valid;
    logic                 row_ready;
    logic [ROW_W-1:0]     row_data;
    logic [PAL_SEL_W-1:0] row_pal;
    logic                 row_hflip;
    logic                 pix_en;
    logic                 blank;
    logic [PAL_SEL_W-1:0] pal_addr;
    logic [PAL_ROW_W-1:0] pal_data;
    logic [COLOR_W-1:0]   rgb_out;
    logic                 rgb_valid;
    logic                 underrun;

    modport master (
        output row_valid, row_data, row_pal, row_hflip, pix_en, blank, pal_data,
        input  row_ready, pal_addr, rgb_out, rgb_valid, underrun
    );

    modport slave (
        input  row_valid, row_data, row_pal, row_hflip, pix_en, blank, pal_data,
        output row_ready, pal_addr, rgb_out, rgb_valid, underrun
    );

endinterface

// File: rtl/palette_pixel_shifter_pal_entry_select.sv
// Output stage: picks one entry from the palette RAM row and registers its RGB bits.
module palette_pixel_shifter_pal_entry_select
    import palette_pixel_shifter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    input  logic                 i_bg,
    input  logic [BPP-1:0]       i_idx,
    input  logic [PAL_ROW_W-1:0] i_pal_data,
    output logic [COLOR_W-1:0]   o_rgb,
    output logic                 o_rgb_valid
);

    logic [N_ENTRIES-1:0][ENTRY_W-1:0] w_entries;

    assign w_entries = i_pal_data;

    // Idle slots retire as colour 0; starved slots retire as the background colour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rgb       <= '0;
            o_rgb_valid <= 1'b0;
        end else begin
            o_rgb_valid <= i_valid;
            if (!i_valid)
                o_rgb <= '0;
            else if (i_bg)
                o_rgb <= BG_COLOR;
            else
                o_rgb <= w_entries[i_idx][COLOR_W-1:0];
        end
    end

endmodule

// File: rtl/palette_pixel_shifter.sv
// Double-buffered 4bpp row serialiser feeding a 1-clock palette RAM; emits 12-bit RGB per pixel strobe.
module palette_pixel_shifter
    import palette_pixel_shifter_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    palette_pixel_shifter_if.slave  bus
);

    row_t                 r_sh;
    row_t                 r_hold;
    logic                 r_hold_full;
    logic [CNT_W-1:0]     r_px_cnt;
    logic [PAL_SEL_W-1:0] r_pal_addr;
    logic                 r_v_s1;
    logic                 r_bg_s1;
    logic [BPP-1:0]       r_idx_s1;
    logic                 r_v_s2;
    logic                 r_bg_s2;
    logic [BPP-1:0]       r_idx_s2;
    logic                 r_underrun;

    row_t                 w_in;
    row_t                 w_sh_nxt;
    row_t                 w_hold_nxt;
    logic                 w_hold_full_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_accept;
    logic                 w_active;
    logic                 w_consume;
    logic                 w_starve;
    logic                 w_sh_free;

    assign w_in          = {bus.row_data, bus.row_pal, bus.row_hflip};
    assign bus.row_ready = !r_hold_full;
    assign bus.pal_addr  = r_pal_addr;
    assign bus.underrun  = r_underrun;

    assign w_accept  = bus.row_valid && !r_hold_full;
    assign w_active  = bus.pix_en && !bus.blank;
    assign w_consume = w_active && (r_px_cnt != '0);
    assign w_starve  = w_active && (r_px_cnt == '0);
    // Shifter can take a new row this edge: already empty, or emitting its last pixel.
    assign w_sh_free = (r_px_cnt == '0) || (w_consume && (r_px_cnt == CNT_W'(1)));

    always_comb begin
        w_sh_nxt        = r_sh;
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
        w_cnt_nxt       = r_px_cnt;
        if (w_consume) begin
            w_sh_nxt  = row_advance(r_sh);
            w_cnt_nxt = r_px_cnt - CNT_W'(1);
        end
        if (w_sh_free) begin
            if (r_hold_full) begin
                w_sh_nxt        = r_hold;
                w_cnt_nxt       = CNT_W'(PIX_PER_ROW);
                w_hold_full_nxt = 1'b0;
            end else if (w_accept) begin
                w_sh_nxt  = w_in;
                w_cnt_nxt = CNT_W'(PIX_PER_ROW);
            end
        end else if (w_accept) begin
            w_hold_nxt      = w_in;
            w_hold_full_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh        <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_px_cnt    <= '0;
        end else begin
            r_sh        <= w_sh_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_px_cnt    <= w_cnt_nxt;
        end
    end

    // Stage 1 launches the RAM read; stage 2 waits out its latency alongside the index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pal_addr <= '0;
            r_v_s1     <= 1'b0;
            r_bg_s1    <= 1'b0;
            r_idx_s1   <= '0;
            r_v_s2     <= 1'b0;
            r_bg_s2    <= 1'b0;
            r_idx_s2   <= '0;
            r_underrun <= 1'b0;
        end else begin
            if (w_consume)
                r_pal_addr <= r_sh.pal;
            r_v_s1     <= w_consume || w_starve;
            r_bg_s1    <= w_starve;
            r_idx_s1   <= w_consume ? row_head(r_sh) : '0;
            r_v_s2     <= r_v_s1;
            r_bg_s2    <= r_bg_s1;
            r_idx_s2   <= r_idx_s1;
            r_underrun <= w_starve;
        end
    end

    palette_pixel_shifter_pal_entry_select u_sel (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (r_v_s2),
        .i_bg        (r_bg_s2),
        .i_idx       (r_idx_s2),
        .i_pal_data  (bus.pal_data),
        .o_rgb       (bus.rgb_out),
        .o_rgb_valid (bus.rgb_valid)
    );

endmodule

// File: tb/tb_palette_pixel_shifter.sv
// Bench for palette_pixel_shifter: directed and random rows against a pixel-queue reference model.
module tb_palette_pixel_shifter;
    import palette_pixel_shifter_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    palette_pixel_shifter_if bus ();

    palette_pixel_shifter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Palette RAM model: entry n of palette p = {4'h0, p, 1'b0, n, n}, one clock read latency.
    function automatic logic [PAL_ROW_W-1:0] ram_row(input logic [PAL_SEL_W-1:0] p);
        logic [PAL_ROW_W-1:0] r;
        r = '0;
        for (int n = 0; n < int'(N_ENTRIES); n++)
            r[n*ENTRY_W +: ENTRY_W] = {4'h0, p, 1'b0, 4'(n), 4'(n)};
        return r;
    endfunction

    always @(posedge clk) bus.pal_data <= ram_row(bus.pal_addr);

    function automatic logic [COLOR_W-1:0] color_of(input logic [PAL_SEL_W-1:0] p, input logic [BPP-1:0] n);
        return {p, 1'b0, n, n};
    endfunction

    typedef struct {
        logic [COLOR_W-1:0]   col;
        logic [PAL_SEL_W-1:0] pal;
    } px_t;

    px_t                  q[$];
    logic                 e_v0, e_v1, e_vo;
    logic [COLOR_W-1:0]   e_c0, e_c1, e_co;
    logic                 e_und;
    logic [PAL_SEL_W-1:0] e_pal;
    int                   n_cmp  = 0;
    int                   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        e_v0 = 1'b0; e_v1 = 1'b0; e_vo = 1'b0;
        e_c0 = '0;   e_c1 = '0;   e_co = '0;
        e_und = 1'b0;
        e_pal = '0;
    endtask

    task automatic drive(input logic rv, input logic [ROW_W-1:0] d, input logic [PAL_SEL_W-1:0] p,
                         input logic hf, input logic pe, input logic bl);
        bus.row_valid = rv;
        bus.row_data  = d;
        bus.row_pal   = p;
        bus.row_hflip = hf;
        bus.pix_en    = pe;
        bus.blank     = bl;
    endtask

    // One clock: predict from the current inputs, let the edge happen, compare the outputs.
    task automatic tick(output logic acc);
        logic             ready;
        logic             act;
        px_t              px;
        logic [ROW_W-1:0] d;
        int               s;
        ready = (q.size() <= int'(PIX_PER_ROW));
        check("row_ready", 32'(bus.row_ready), 32'(ready));
        acc  = bus.row_valid && ready;
        act  = bus.pix_en && !bus.blank;
        e_vo = e_v1; e_co = e_c1;
        e_v1 = e_v0; e_c1 = e_c0;
        e_v0 = 1'b0; e_c0 = '0; e_und = 1'b0;
        if (act) begin
            e_v0 = 1'b1;
            if (q.size() != 0) begin
                px    = q.pop_front();
                e_c0  = px.col;
                e_pal = px.pal;
            end else begin
                e_c0  = BG_COLOR;
                e_und = 1'b1;
            end
        end
        if (acc) begin
            d = bus.row_data;
            for (int k = 0; k < int'(PIX_PER_ROW); k++) begin
                s = bus.row_hflip ? (int'(PIX_PER_ROW) - 1 - k) : k;
                q.push_back('{col: color_of(bus.row_pal, d[s*BPP +: BPP]), pal: bus.row_pal});
            end
        end
        @(posedge clk);
        #1;
        check("rgb_valid", 32'(bus.rgb_valid), 32'(e_vo));
        check("rgb_out",   32'(bus.rgb_out),   32'(e_co));
        check("underrun",  32'(bus.underrun),  32'(e_und));
        check("pal_addr",  32'(bus.pal_addr),  32'(e_pal));
    endtask

    initial begin
        logic             acc;
        logic [ROW_W-1:0] rows [3];
        int               ri;

        model_clear();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        #12;
        check("rst_rgb_out",   32'(bus.rgb_out),   32'h0);
        check("rst_rgb_valid", 32'(bus.rgb_valid), 32'h0);
        check("rst_underrun",  32'(bus.underrun),  32'h0);
        check("rst_pal_addr",  32'(bus.pal_addr),  32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_row_ready", 32'(bus.row_ready), 32'h1);

        // Single row, pal 3, strobe every clock.
        drive(1'b1, 32'h7654_3210, 3'd3, 1'b0, 1'b0, 1'b0);
        tick(acc);
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, '0, '0, 1'b0, k < 8, 1'b0);
            tick(acc);
            if (k >= 2)
                check("t2_pixel", 32'(bus.rgb_out), 32'h600 + 32'h011 * 32'(k - 2));
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick(acc);

        // Two rows back to back, second mirrored.
        drive(1'b1, 32'hFEDC_BA98, 3'd1, 1'b0, 1'b0, 1'b0);
        tick(acc);
        drive(1'b1, 32'h7654_3210, 3'd5, 1'b1, 1'b1, 1'b0);
        tick(acc);
        for (int k = 0; k < 18; k++) begin
            drive(1'b0, '0, '0, 1'b0, k < 15, 1'b0);
            tick(acc);
        end

        // Strobe with nothing loaded.
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        tick(acc);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick(acc);
        tick(acc);
        check("t4_bg_valid", 32'(bus.rgb_valid), 32'h1);
        check("t4_bg_color", 32'(bus.rgb_out),   32'(BG_COLOR));

        // Blank for three clocks mid-row with strobe held high.
        drive(1'b1, 32'h1357_9BDF, 3'd6, 1'b0, 1'b0, 1'b0);
        tick(acc);
        for (int k = 0; k < 14; k++) begin
            drive(1'b0, '0, '0, 1'b0, k < 11, k >= 3 && k < 6);
            tick(acc);
        end

        // Continuous supply: rows offered while hold is full and the last pixel shifts out.
        rows[0] = 32'h0123_4567; rows[1] = 32'h89AB_CDEF; rows[2] = 32'h2468_ACE0;
        ri = 0;
        for (int k = 0; k < 40; k++) begin
            drive(ri < 3, (ri < 3) ? rows[ri] : '0, 3'(ri + 2), ri == 1, 1'b1, 1'b0);
            tick(acc);
            if (acc) ri++;
        end
        check("t6_rows_taken", 32'(ri), 32'd3);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick(acc);
        tick(acc);

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            drive($urandom_range(0, 2) == 0, ROW_W'($urandom), 3'($urandom), 1'($urandom),
                  $urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0);
            tick(acc);
        end

        // Reset while both buffers hold pixels.
        drive(1'b1, 32'hAAAA_5555, 3'd7, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) tick(acc);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check("mid_rst_rgb_out",   32'(bus.rgb_out),   32'h0);
        check("mid_rst_rgb_valid", 32'(bus.rgb_valid), 32'h0);
        check("mid_rst_pal_addr",  32'(bus.pal_addr),  32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        #1;
        check("mid_rst_row_ready", 32'(bus.row_ready), 32'h1);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) tick(acc);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) tick(acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
